// File: rtl/decode_bitin_p_if.sv
// decode_bitin_p_if: source-FIFO, parser-stream and status signals of the bit extractor.
interface decode_bitin_p_if #(
   parameter int IN_W   = 64,
   parameter int PEEK_W = 13,
   parameter int WID_W  = 4,
   parameter int LVL_W  = $clog2(2*IN_W+1)
);
   logic              ce;
   logic              fo_full;
   logic              src_empty;
   logic [IN_W-1:0]   fi;
   logic              src_eos;
   logic              m_src_getn;
   logic [PEEK_W-1:0] stream_data;
   logic              stream_valid;
   logic [LVL_W-1:0]  stream_level;
   logic [WID_W-1:0]  stream_width;
   logic              stream_ack;
   logic              stream_align;
   logic [31:0]       bit_pos;
   logic              stream_err;
   modport master (
      input  ce, fo_full, src_empty, fi, src_eos, stream_width, stream_ack, stream_align,
      output m_src_getn, stream_data, stream_valid, stream_level, bit_pos, stream_err
   );
   modport slave (
      output ce, fo_full, src_empty, fi, src_eos, stream_width, stream_ack, stream_align,
      input  m_src_getn, stream_data, stream_valid, stream_level, bit_pos, stream_err
   );
endinterface

// File: rtl/decode_bitin_p.sv
// decode_bitin_p: pops FWFT source words into a left-aligned shift buffer and
// presents an MSB-first peek window that the parser consumes bit-wise.
module decode_bitin_p #(
   parameter int IN_W   = 64,
   parameter int PEEK_W = 13,
   parameter int WID_W  = 4,
   parameter int LVL_W  = $clog2(2*IN_W+1)
) (
   input logic               clk,
   input logic               rst,
   decode_bitin_p_if.master  bus_io
);
   localparam int BUF_W = 2*IN_W;
   logic [BUF_W-1:0] sbuf_q, sbuf_d, cons_buf;
   logic [LVL_W-1:0] level_q, level_d, cons_lvl;
   logic [31:0]      bit_pos_q, bit_pos_d, pos_w, w, n;
   logic [2:0]       pad;
   logic             err_q, err_d, drain, valid, take, bad, pop;
   always_comb begin
      drain    = bus_io.src_eos & bus_io.src_empty;
      valid    = bus_io.ce & ~bus_io.fo_full &
                 (32'(level_q) >= PEEK_W | (drain & level_q != '0));
      take     = valid & (bus_io.stream_ack | bus_io.stream_align);
      w        = bus_io.stream_ack ? 32'(bus_io.stream_width) : 32'd0;
      pos_w    = bit_pos_q + w;
      pad      = bus_io.stream_align ? 3'd0 - pos_w[2:0] : 3'd0;
      n        = w + 32'(pad);
      bad      = take & (n > 32'(level_q) |
                 (bus_io.stream_ack & 32'(bus_io.stream_width) > PEEK_W));
      cons_buf = bad ? '0 : take ? sbuf_q << n : sbuf_q;
      cons_lvl = bad ? '0 : take ? level_q - LVL_W'(n) : level_q;
      // the new word lands directly below whatever survives this cycle's consume
      pop      = rst & bus_io.ce & ~bus_io.src_empty & (32'(level_q) <= IN_W);
      sbuf_d   = pop ? cons_buf | ({bus_io.fi, {IN_W{1'b0}}} >> cons_lvl) : cons_buf;
      level_d  = pop ? cons_lvl + LVL_W'(IN_W) : cons_lvl;
      bit_pos_d = (take & ~bad) ? bit_pos_q + n : bit_pos_q;
      err_d    = err_q | bad;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sbuf_q    <= '0;
         level_q   <= '0;
         bit_pos_q <= '0;
         err_q     <= 1'b0;
      end else if (bus_io.ce) begin
         sbuf_q    <= sbuf_d;
         level_q   <= level_d;
         bit_pos_q <= bit_pos_d;
         err_q     <= err_d;
      end
   end
   assign bus_io.m_src_getn   = ~pop;
   assign bus_io.stream_data  = sbuf_q[BUF_W-1 -: PEEK_W];
   assign bus_io.stream_valid = valid;
   assign bus_io.stream_level = level_q;
   assign bus_io.bit_pos      = bit_pos_q;
   assign bus_io.stream_err   = err_q;
endmodule

// File: doc/decode_bitin_p.md
# decode_bitin_p

Parametrised bit-stream extractor at the front of the LZS decoder. Pops fixed-width words from a first-word-fall-through source FIFO, holds them in a left-aligned shift buffer, and presents a PEEK_W-bit MSB-first window to the token parser, which consumes a variable number of bits per cycle. Adds end-of-stream drain, byte-boundary realignment, a consumed-bit counter and error flagging.

## Interface
- IN_W, 64: source word width; multiple of 8, ≥ PEEK_W.
- PEEK_W, 13: window width presented to the parser; ≥ 8.
- WID_W, 4: width of the consume-count port; every legal count is ≤ PEEK_W.
- LVL_W, $clog2(2*IN_W+1): buffer-level width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; 0 freezes all state.
- fo_full  in  1  downstream output FIFO full; stalls consumption.
- src_empty  in  1  source FIFO empty.
- fi  in  IN_W  source head word (FWFT), MSB is the first stream bit.
- src_eos  in  1  no further words will arrive once src_empty=1.
- m_src_getn  out  1  active-low pop strobe to source FIFO.
- stream_data  out  PEEK_W  next PEEK_W stream bits, MSB first; zero-padded below level.
- stream_valid  out  1  window usable this cycle.
- stream_level  out  LVL_W  valid bits held in the buffer.
- stream_width  in  WID_W  bits to consume on ack.
- stream_ack  in  1  consume stream_width bits.
- stream_align  in  1  after the ack width, also drop bits up to the next byte boundary.
- bit_pos  out  32  total bits consumed since reset, wraps modulo 2^32.
- stream_err  out  1  sticky protocol error.

## Operation
- State: buf[2*IN_W-1:0] (left-aligned), level, bit_pos, stream_err.
- stream_data = buf[2*IN_W-1 -: PEEK_W]; bits at and below level are always 0.
- drain = src_eos & src_empty.
- stream_valid = ce & ~fo_full & (level ≥ PEEK_W | (drain & level > 0)).
- Consume: taken when stream_valid & (stream_ack | stream_align). w = stream_ack ? stream_width : 0. pad = (8 − ((bit_pos + w) mod 8)) mod 8 when stream_align, else 0. n = w + pad.
- If n ≤ level: buf shifts left by n, level −= n, bit_pos += n.
- If n > level, or stream_width > PEEK_W with ack: stream_err ← 1, level ← 0, buf ← 0, bit_pos unchanged.
- Refill: pop = ce & ~src_empty & (level ≤ IN_W); m_src_getn = ~pop, combinational from registered level, src_empty and ce only. The popped word lands at bit offset (level − n) from the MSB after the same-cycle consume; level_next = level − n + IN_W.
- Consume and pop in the same cycle are both applied.
- ce=0: m_src_getn=1, stream_valid=0, no state change.
- fo_full=1: stream_valid=0 and acks are ignored; refill continues.

## Timing
- Reset, asynchronous: buf=0, level=0, bit_pos=0, stream_err=0, hence stream_valid=0, stream_data=0, stream_level=0. m_src_getn=1 while rst=0.
- Latency: fi is popped in cycle t, and stream_valid=1 with the new window in cycle t+1.
- Sustained rate: one consume per cycle at any width ≤ PEEK_W with no bubbles, provided the source is non-empty. Buffer level after a pop is always ≥ IN_W ≥ PEEK_W.
- Reset asserted mid-stream: all state clears immediately. On release the first pop happens on the first edge where src_empty=0.
- Level bounds: 0 ≤ level ≤ 2*IN_W, and level never exceeds 2*IN_W because a pop requires level ≤ IN_W.

## Test plan
- Reset release, src_empty=0, fi=64'hA5C3_0000_0000_0001 -> m_src_getn=0 in cycle 0; in cycle 1 stream_valid=1, stream_data=13'h14B8, stream_level=64.
- Same state, then ack with stream_width=9 -> stream_data=13'h10C0, level=55, bit_pos=9. With stream_align=1 also asserted instead -> n=16, level=48, bit_pos=16, stream_data=0.
- Continuous acks of width 13 with the source always full -> stream_valid stays 1 on every cycle; a pop occurs whenever level ≤ 64; bit_pos advances by 13 per cycle; stream_err=0.
- Last word popped with src_eos=1 and src_empty=1, level draining to 9 -> stream_valid=1 with data zero-padded. Ack width 9 -> level 0, stream_valid=0. Ack width 10 instead -> stream_err=1, level 0.
- fo_full=1 or ce=0 with stream_ack=1 -> no consume, bit_pos unchanged. With ce=0, m_src_getn=1; with fo_full=1 and level ≤ 64, the pop still occurs.
- rst pulled low mid-stream with level=40, bit_pos=1000 -> outputs return to their reset values asynchronously. After release the stream restarts from the FIFO head with bit_pos=0.
